// File: rtl/cam_pixel_assembler.sv
// -----------------------------------------------------------------------------
// cam_pixel_assembler
//
// Pixel-capture stage in front of the camera controller. It samples the
// OV-style parallel bus (VSYNC / HREF / 8-bit data) on PCLK, pairs bytes into
// 16-bit RGB565 words, and keeps the byte count within the current line and
// the line count within the current frame.
//
// Parameters:
//   LINE_BYTES      expected bytes per line (2 per pixel)
//   MAX_LINES       saturation value of the line counter (9 bits)
//   FIRST_BYTE_HIGH 1: first byte of a pair -> [15:8]; 0: first byte -> [7:0]
//
// Ports:
//   clk            pixel clock (PCLK), single clock domain
//   reset          synchronous, active-high reset
//   CamVsync       frame sync, high = vertical blank
//   CamHsync       HREF, high = valid line bytes
//   CamData_in     camera byte
//   test_mode      (only with CAM_TEST_PATTERN_EN) replace data by colour bars
//   CamData_out    assembled pixel
//   CamData_enable one-cycle pulse, CamData_out valid
//   CamPix_count   bytes received in the current line, saturates at 2047
//   CamHsync_count lines started in the current frame, saturates at MAX_LINES
//   frame_done     one-cycle pulse at the end of a captured frame
//   line_err       sticky per frame: some line length differed from LINE_BYTES
//   in_frame       high while the FSM is in S_FRAME
//
// Optional feature macro: CAM_TEST_PATTERN_EN (adds test_mode and an
// 8-bar colour pattern generator, 80 pixels per bar).
//
// Handshake: there is no back-pressure. CamData_enable is a valid-only strobe;
// the consumer must take CamData_out in the cycle the strobe is high.
// -----------------------------------------------------------------------------
module cam_pixel_assembler #(
  parameter int unsigned LINE_BYTES      = 1280,
  parameter int unsigned MAX_LINES       = 511,
  parameter int unsigned FIRST_BYTE_HIGH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CamVsync,
  input  logic        CamHsync,
  input  logic [7:0]  CamData_in,
`ifdef CAM_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [15:0] CamData_out,
  output logic        CamData_enable,
  output logic [10:0] CamPix_count,
  output logic [8:0]  CamHsync_count,
  output logic        frame_done,
  output logic        line_err,
  output logic        in_frame
);

  localparam logic [10:0] LINE_BYTES_C = 11'(LINE_BYTES);
  localparam logic [8:0]  MAX_LINES_C  = 9'(MAX_LINES);
  localparam logic [10:0] PIX_SAT_C    = 11'h7FF;

  typedef enum logic [1:0] {
    S_WAIT_VSYNC = 2'd0,
    S_VBLANK     = 2'd1,
    S_FRAME      = 2'd2
  } state_t;

  // Input stage: one register on every pin plus a delayed copy for edges.
  logic        s_vs_q, s_vs_d;
  logic        s_hs_q, s_hs_d;
  logic [7:0]  s_d_q, s_d_d;
  logic        s_vs_dly_q, s_vs_dly_d;
  logic        s_hs_dly_q, s_hs_dly_d;

  // Capture state.
  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] data_q, data_d;
  logic        en_q, en_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [8:0]  line_cnt_q, line_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        line_err_q, line_err_d;

`ifdef CAM_TEST_PATTERN_EN
  // Bar position: pixel within the current bar (0..79) and bar number (0..7).
  logic [6:0]  bar_px_q, bar_px_d;
  logic [2:0]  bar_idx_q, bar_idx_d;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF; // white
      3'd1:    c = 16'hFFE0; // yellow
      3'd2:    c = 16'h07FF; // cyan
      3'd3:    c = 16'h07E0; // green
      3'd4:    c = 16'hF81F; // magenta
      3'd5:    c = 16'hF800; // red
      3'd6:    c = 16'h001F; // blue
      default: c = 16'h0000; // black
    endcase
    return c;
  endfunction
`endif

  // Edge detects on the registered syncs.
  logic vs_rise, vs_fall, hs_rise, hs_fall;
  assign vs_rise = s_vs_q & ~s_vs_dly_q;
  assign vs_fall = ~s_vs_q & s_vs_dly_q;
  assign hs_rise = s_hs_q & ~s_hs_dly_q;
  assign hs_fall = ~s_hs_q & s_hs_dly_q;

  // Counter and phase as seen by the byte of this cycle: a line start
  // restarts both before the first byte is counted.
  logic [10:0] base_cnt;
  logic        base_phase;
  logic [15:0] cam_word;

  always_comb begin
    // Input stage
    s_vs_d     = CamVsync;
    s_hs_d     = CamHsync;
    s_d_d      = CamData_in;
    s_vs_dly_d = s_vs_q;
    s_hs_dly_d = s_hs_q;

    // Defaults: hold everything, strobes low
    state_d      = state_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    data_d       = data_q;
    en_d         = 1'b0;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;
    base_cnt     = pix_cnt_q;
    base_phase   = phase_q;
`ifdef CAM_TEST_PATTERN_EN
    bar_px_d     = bar_px_q;
    bar_idx_d    = bar_idx_q;
`endif

    if (FIRST_BYTE_HIGH != 0) begin
      cam_word = {hold_q, s_d_q};
    end else begin
      cam_word = {s_d_q, hold_q};
    end

    case (state_q)
      S_WAIT_VSYNC: begin
        // Wait for a blank so the first captured frame is complete.
        if (s_vs_q) begin
          state_d = S_VBLANK;
        end
      end

      S_VBLANK: begin
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        line_err_d = 1'b0;
        phase_d    = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
        bar_px_d   = '0;
        bar_idx_d  = '0;
`endif
        if (vs_fall) begin
          state_d = S_FRAME;
        end
      end

      S_FRAME: begin
        if (vs_rise) begin
          // End of frame takes priority over anything on HREF this cycle.
          frame_done_d = 1'b1;
          state_d      = S_VBLANK;
        end else begin
          if (hs_fall && (pix_cnt_q != LINE_BYTES_C)) begin
            line_err_d = 1'b1;
          end

          if (s_hs_q) begin
            if (hs_rise) begin
              base_cnt   = '0;
              base_phase = 1'b0;
              if (line_cnt_q < MAX_LINES_C) begin
                line_cnt_d = line_cnt_q + 9'd1;
              end
`ifdef CAM_TEST_PATTERN_EN
              bar_px_d  = '0;
              bar_idx_d = '0;
`endif
            end

            pix_cnt_d = (base_cnt == PIX_SAT_C) ? base_cnt : base_cnt + 11'd1;
            phase_d   = ~base_phase;

            if (!base_phase) begin
              hold_d = s_d_q;
            end else if (base_cnt < LINE_BYTES_C) begin
              // Second byte of a pair inside the nominal line length.
              en_d   = 1'b1;
              data_d = cam_word;
`ifdef CAM_TEST_PATTERN_EN
              if (test_mode) begin
                data_d = bar_colour(bar_idx_q);
              end
              if (bar_px_q == 7'd79) begin
                bar_px_d = '0;
                if (bar_idx_q != 3'd7) begin
                  bar_idx_d = bar_idx_q + 3'd1;
                end
              end else begin
                bar_px_d = bar_px_q + 7'd1;
              end
`endif
            end
          end
        end
      end

      default: begin
        state_d = S_WAIT_VSYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_vs_q       <= 1'b0;
      s_hs_q       <= 1'b0;
      s_d_q        <= '0;
      s_vs_dly_q   <= 1'b0;
      s_hs_dly_q   <= 1'b0;
      state_q      <= S_WAIT_VSYNC;
      phase_q      <= 1'b0;
      hold_q       <= '0;
      data_q       <= '0;
      en_q         <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
`ifdef CAM_TEST_PATTERN_EN
      bar_px_q     <= '0;
      bar_idx_q    <= '0;
`endif
    end else begin
      s_vs_q       <= s_vs_d;
      s_hs_q       <= s_hs_d;
      s_d_q        <= s_d_d;
      s_vs_dly_q   <= s_vs_dly_d;
      s_hs_dly_q   <= s_hs_dly_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      data_q       <= data_d;
      en_q         <= en_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
`ifdef CAM_TEST_PATTERN_EN
      bar_px_q     <= bar_px_d;
      bar_idx_q    <= bar_idx_d;
`endif
    end
  end

  assign CamData_out    = data_q;
  assign CamData_enable = en_q;
  assign CamPix_count   = pix_cnt_q;
  assign CamHsync_count = line_cnt_q;
  assign frame_done     = frame_done_q;
  assign line_err       = line_err_q;
  assign in_frame       = (state_q == S_FRAME);

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// -----------------------------------------------------------------------------
// tb_cam_pixel_assembler
//
// Bench for cam_pixel_assembler. Instance u_hi uses FIRST_BYTE_HIGH=1, u_lo
// uses FIRST_BYTE_HIGH=0; both see the same pins. Expected pixels come from a
// line-level model: every pair of bytes among the first LINE_BYTES of a line
// forms one word, the byte count is the line length, and line_err is set when
// any line length differs from LINE_BYTES.
// -----------------------------------------------------------------------------
module tb_cam_pixel_assembler;

  localparam int LINE_BYTES = 1280;

  typedef logic [7:0] bq_t[$];

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        vs, hs;
  logic [7:0]  din;
`ifdef CAM_TEST_PATTERN_EN
  logic        test_mode;
`endif

  logic [15:0] out_a, out_b;
  logic        en_a, en_b;
  logic [10:0] pc_a, pc_b;
  logic [8:0]  hc_a, hc_b;
  logic        fd_a, fd_b, le_a, le_b, if_a, if_b;

  cam_pixel_assembler #(.LINE_BYTES(1280), .MAX_LINES(511), .FIRST_BYTE_HIGH(1)) u_hi (
    .clk(clk), .reset(reset), .CamVsync(vs), .CamHsync(hs), .CamData_in(din),
`ifdef CAM_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .CamData_out(out_a), .CamData_enable(en_a), .CamPix_count(pc_a),
    .CamHsync_count(hc_a), .frame_done(fd_a), .line_err(le_a), .in_frame(if_a)
  );

  cam_pixel_assembler #(.LINE_BYTES(1280), .MAX_LINES(511), .FIRST_BYTE_HIGH(0)) u_lo (
    .clk(clk), .reset(reset), .CamVsync(vs), .CamHsync(hs), .CamData_in(din),
`ifdef CAM_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .CamData_out(out_b), .CamData_enable(en_b), .CamPix_count(pc_b),
    .CamHsync_count(hc_b), .frame_done(fd_b), .line_err(le_b), .in_frame(if_b)
  );

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] got_b_q[$];
  int          fd_count = 0;
  logic [8:0]  fd_hcount = '0;
  logic        fd_lerr = 1'b0;

  always @(negedge clk) begin
    if (en_a) got_q.push_back(out_a);
    if (en_b) got_b_q.push_back(out_b);
    if (fd_a) begin
      fd_count++;
      fd_hcount = hc_a;
      fd_lerr   = le_a;
    end
  end

  // Model: words expected from one line of bytes
  function automatic void model_line(input bq_t b);
    int usable;
    usable = (b.size() < LINE_BYTES) ? b.size() : LINE_BYTES;
    for (int j = 0; j + 1 < usable; j += 2) exp_q.push_back({b[j], b[j+1]});
  endfunction

  function automatic int first_mismatch();
    int r;
    r = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (r < 0 && got_q[i] !== exp_q[i]) r = i;
    return r;
  endfunction

  function automatic bq_t ramp(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'(k));
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Drivers
  task automatic step(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    vs = v; hs = h; din = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(vs, 1'b0, 8'h00);
  endtask

  task automatic vblank();
    repeat (4) step(1'b1, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input bq_t b);
    for (int i = 0; i < b.size(); i++) step(1'b0, 1'b1, b[i]);
    step(1'b0, 1'b0, 8'h00);
    idle(4);
  endtask

  task automatic clear_sb();
    got_q.delete(); got_b_q.delete(); exp_q.delete();
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1; vs = 1'b0; hs = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out_a); end
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en_a); end
    checks++; if (pc_a !== 11'd0 || hc_a !== 9'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", pc_a, hc_a); end
    checks++; if ({fd_a, le_a, if_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {fd_a, le_a, if_a}); end
    reset = 1'b0;
    clear_sb();
    send_line(ramp(20));
    send_line(ramp(20));
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL pre_vsync_en got=%0d exp=0", got_q.size()); end
    checks++; if (hc_a !== 9'd0 || if_a !== 1'b0) begin errors++; $display("FAIL pre_vsync_hc got=%0d/%b exp=0/0", hc_a, if_a); end
  endtask

  task automatic test_frame();
    bq_t b;
    int fd0, m;
    clear_sb();
    vblank();
    checks++; if (if_a !== 1'b1) begin errors++; $display("FAIL frame_in_frame got=%b exp=1", if_a); end
    for (int l = 0; l < 3; l++) begin
      b = ramp(1280);
      model_line(b);
      send_line(b);
      checks++; if (hc_a !== 9'(l + 1)) begin errors++; $display("FAIL frame_hcount got=%0d exp=%0d", hc_a, l + 1); end
      checks++; if (pc_a !== 11'd1280) begin errors++; $display("FAIL frame_pcount got=%0d exp=1280", pc_a); end
    end
    checks++; if (got_q.size() !== 1920) begin errors++; $display("FAIL frame_en_count got=%0d exp=1920", got_q.size()); end
    m = first_mismatch();
    checks++; if (m !== -1) begin errors++; $display("FAIL frame_data idx=%0d got=%h exp=%h", m, got_q[m], exp_q[m]); end
    checks++; if (got_q.size() > 639 && (got_q[0] !== 16'h0001 || got_q[639] !== 16'hFEFF))
      begin errors++; $display("FAIL frame_first_last got=%h/%h exp=0001/feff", got_q[0], got_q[639]); end
    fd0 = fd_count;
    step(1'b1, 1'b0, 8'h00);
    idle(4);
    checks++; if (fd_count !== fd0 + 1) begin errors++; $display("FAIL frame_done_pulses got=%0d exp=%0d", fd_count - fd0, 1); end
    checks++; if (fd_hcount !== 9'd3 || fd_lerr !== 1'b0) begin errors++; $display("FAIL frame_done_state got=%0d/%b exp=3/0", fd_hcount, fd_lerr); end
    checks++; if (if_a !== 1'b0 || hc_a !== 9'd0) begin errors++; $display("FAIL vblank_clear got=%b/%0d exp=0/0", if_a, hc_a); end
  endtask

  task automatic test_pairing();
    clear_sb();
    vblank();
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 8'h00);
    checks++; if (en_b !== 1'b0) begin errors++; $display("FAIL pair_early_en got=%b exp=0", en_b); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (en_b !== 1'b1) begin errors++; $display("FAIL pair_latency_en got=%b exp=1", en_b); end
    checks++; if (out_b !== 16'h3CA5) begin errors++; $display("FAIL pair_low_first got=%h exp=3ca5", out_b); end
    checks++; if (out_a !== 16'hA53C) begin errors++; $display("FAIL pair_high_first got=%h exp=a53c", out_a); end
    idle(4);
    checks++; if (got_b_q.size() !== 1) begin errors++; $display("FAIL pair_en_count got=%0d exp=1", got_b_q.size()); end
  endtask

  task automatic test_short_line();
    bq_t b;
    int m;
    vblank();
    checks++; if (le_a !== 1'b0) begin errors++; $display("FAIL short_err_cleared got=%b exp=0", le_a); end
    clear_sb();
    b = rand_bytes(1278);
    model_line(b);
    send_line(b);
    checks++; if (got_q.size() !== 639) begin errors++; $display("FAIL short_en_count got=%0d exp=639", got_q.size()); end
    m = first_mismatch();
    checks++; if (m !== -1) begin errors++; $display("FAIL short_data idx=%0d got=%h exp=%h", m, got_q[m], exp_q[m]); end
    checks++; if (le_a !== 1'b1 || pc_a !== 11'd1278) begin errors++; $display("FAIL short_err got=%b/%0d exp=1/1278", le_a, pc_a); end
    vblank();
    checks++; if (le_a !== 1'b0) begin errors++; $display("FAIL short_err_vblank got=%b exp=0", le_a); end
  endtask

  task automatic test_long_line();
    bq_t b;
    int m, fd0;
    clear_sb();
    b = rand_bytes(1282);
    model_line(b);
    send_line(b);
    checks++; if (got_q.size() !== 640) begin errors++; $display("FAIL long_en_count got=%0d exp=640", got_q.size()); end
    m = first_mismatch();
    checks++; if (m !== -1) begin errors++; $display("FAIL long_data idx=%0d got=%h exp=%h", m, got_q[m], exp_q[m]); end
    checks++; if (pc_a !== 11'd1282 || le_a !== 1'b1) begin errors++; $display("FAIL long_count got=%0d/%b exp=1282/1", pc_a, le_a); end
    fd0 = fd_count;
    step(1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b1, 8'h78);
    idle(4);
    checks++; if (fd_count !== fd0 + 1 || fd_hcount !== 9'd1) begin errors++; $display("FAIL vs_hs_together got=%0d/%0d exp=1/1", fd_count - fd0, fd_hcount); end
    checks++; if (got_q.size() !== 640) begin errors++; $display("FAIL vs_hs_no_byte got=%0d exp=640", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    bq_t b;
    int fd0, m;
    vblank();
    b = rand_bytes(500);
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, b[i]);
    fd0 = fd_count;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++; if ({out_a, en_a, pc_a, hc_a, fd_a, le_a, if_a} !== '0)
      begin errors++; $display("FAIL reset_mid got=%h/%b/%0d/%0d/%b%b%b exp=all_zero", out_a, en_a, pc_a, hc_a, fd_a, le_a, if_a); end
    reset = 1'b0;
    clear_sb();
    send_line(rand_bytes(100));
    checks++; if (got_q.size() !== 0 || fd_count !== fd0) begin errors++; $display("FAIL reset_mid_ignored got=%0d/%0d exp=0/0", got_q.size(), fd_count - fd0); end
    repeat (3) step(1'b1, 1'b0, 8'h00);
    checks++; if (if_a !== 1'b0) begin errors++; $display("FAIL reset_mid_vs_high got=%b exp=0", if_a); end
    vblank();
    b = rand_bytes(1280);
    model_line(b);
    send_line(b);
    m = first_mismatch();
    checks++; if (got_q.size() !== 640 || m !== -1) begin errors++; $display("FAIL reset_mid_resume got=%0d/%0d exp=640/-1", got_q.size(), m); end
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_random_frames();
    bq_t b;
    int len, m, fd0;
    logic exp_err;
    for (int f = 0; f < 2; f++) begin
      clear_sb();
      vblank();
      exp_err = 1'b0;
      for (int l = 0; l < 3; l++) begin
        case ($urandom_range(0, 3))
          0:       len = 1280;
          1:       len = 1278;
          2:       len = 1282;
          default: len = $urandom_range(1270, 1290);
        endcase
        if (len != LINE_BYTES) exp_err = 1'b1;
        b = rand_bytes(len);
        model_line(b);
        send_line(b);
        checks++; if (pc_a !== 11'(len) || hc_a !== 9'(l + 1)) begin errors++; $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", pc_a, hc_a, len, l + 1); end
      end
      m = first_mismatch();
      checks++; if (got_q.size() !== exp_q.size() || m !== -1)
        begin errors++; $display("FAIL rand_data got=%0d/%0d exp=%0d/-1", got_q.size(), m, exp_q.size()); end
      fd0 = fd_count;
      step(1'b1, 1'b0, 8'h00);
      idle(4);
      checks++; if (fd_count !== fd0 + 1 || fd_lerr !== exp_err) begin errors++; $display("FAIL rand_frame_end got=%0d/%b exp=1/%b", fd_count - fd0, fd_lerr, exp_err); end
    end
  endtask

`ifdef CAM_TEST_PATTERN_EN
  task automatic test_pattern();
    test_mode = 1'b1;
    clear_sb();
    vblank();
    send_line(rand_bytes(1280));
    checks++; if (got_q.size() !== 640) begin errors++; $display("FAIL pattern_count got=%0d exp=640", got_q.size()); end
    checks++; if (got_q.size() == 640 && (got_q[0] !== 16'hFFFF || got_q[80] !== 16'hFFE0 || got_q[639] !== 16'h0000))
      begin errors++; $display("FAIL pattern_bars got=%h/%h/%h exp=ffff/ffe0/0000", got_q[0], got_q[80], got_q[639]); end
    step(1'b1, 1'b0, 8'h00);
    test_mode = 1'b0;
  endtask
`endif

  initial begin
`ifdef CAM_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    test_reset();
    test_frame();
    test_pairing();
    test_short_line();
    test_long_line();
    test_reset_mid();
    test_random_frames();
`ifdef CAM_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
